// File: rtl/bcm_preimage_scan.sv
// Sequential inverse of the fixed 3-to-2 bcm code table: walks inputs 0..7 in
// ascending order and hands out every input whose code matches the target.
module bcm_preimage_scan (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] code_i,
  output logic       busy_o,
  output logic       out_valid_o,
  output logic [2:0] out_data_o,
  input  logic       out_ready_i,
  output logic       done_o,
  output logic [2:0] count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [1:0]  code_q;
  logic        out_valid_q;
  logic [2:0]  out_data_q;
  logic [2:0]  count_q;
  logic        match_d;

  function automatic logic [1:0] bcm_code(input logic [2:0] x);
    logic [1:0] c;
    case (x)
      3'd0:    c = 2'b11;
      3'd1:    c = 2'b01;
      3'd2:    c = 2'b11;
      3'd3:    c = 2'b00;
      3'd4:    c = 2'b11;
      3'd5:    c = 2'b11;
      3'd6:    c = 2'b00;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  assign match_d = (bcm_code(idx_q) == code_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      code_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 3'd0;
      count_q     <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            code_q  <= code_i;
            idx_q   <= 3'd0;
            count_q <= 3'd0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (match_d) begin
            out_valid_q <= 1'b1;
            out_data_q  <= idx_q;
            state_q     <= S_HOLD;
          end else if (idx_q == 3'd7) begin
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        S_HOLD: begin
          // idx stays put while holding so the scan resumes just past the match
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            count_q     <= count_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_bcm_preimage_scan.sv
// Bench for bcm_preimage_scan: directed scenarios plus randomized scans checked
// against a table-driven transaction model of the expected match sequence.
module tb_bcm_preimage_scan;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] code;
  logic       busy;
  logic       out_valid;
  logic [2:0] out_data;
  logic       out_ready;
  logic       done;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;
  int F[8] = '{3, 1, 3, 0, 3, 3, 0, 0};

  bcm_preimage_scan dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .code_i      (code),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .done_o      (done),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_count"}, count, 0);
  endtask

  // One full scan. stall_n >= 0: ready held low that many cycles per match;
  // stall_n < 0: random stalls. poke drives ignored starts mid-scan and in DONE.
  task automatic run_scan(input logic [1:0] c, input int stall_n, input bit poke);
    int exp_q[$];
    int m, t, prev_hold, hold, stall_left, total_stall, rx;
    bit pending, acc, got_done;
    logic [2:0] held;
    for (int i = 0; i < 8; i++) if (F[i] == int'(c)) exp_q.push_back(i);
    m = exp_q.size();
    start = 1'b1; code = c; out_ready = 1'b1;
    step();
    start = 1'b0; code = 2'($urandom_range(0, 3));
    chk("busy_after_start", busy, 1);
    t = 1; prev_hold = 0; hold = 0; stall_left = 0; total_stall = 0; rx = 0;
    pending = 0; acc = 0; got_done = 0; held = '0;
    while (!got_done && t < 300) begin
      if (acc) begin
        acc = 0; pending = 0; prev_hold += hold; rx++;
        void'(exp_q.pop_front());
        chk("count_running", count, rx);
      end
      if (out_valid && !pending) begin
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", out_valid, 0);
        end else begin
          pending = 1; hold = 0; held = out_data;
          stall_left = (stall_n < 0) ? int'($urandom_range(0, 3)) : stall_n;
          chk("valid_cycle", t, exp_q[0] + 2 + prev_hold);
          chk("out_data", out_data, exp_q[0]);
        end
      end
      if (pending) begin
        hold++;
        if (hold > 1) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, held);
        end
        if (stall_left > 0) begin
          out_ready = 1'b0; stall_left--; total_stall++;
        end else begin
          out_ready = 1'b1; acc = 1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (poke && t == 4) begin start = 1'b1; code = 2'd0; end
      if (poke && t == 5) start = 1'b0;
      if (done) begin
        got_done = 1;
        chk("done_cycle", t, 9 + m + total_stall);
        chk("done_busy", busy, 1);
        chk("done_count", count, m);
        chk("rx_matches", rx, m);
        if (poke) begin start = 1'b1; code = 2'd0; end
      end else begin
        step();
        t++;
      end
    end
    if (!got_done) chk("done_timeout", got_done, 1);
    out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_valid", out_valid, 0);
    chk("post_count", count, m);
    if (poke) begin
      step();
      chk("start_in_done_ignored", busy, 0);
      chk("count_hold_poke", count, m);
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; code = 2'd0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_idle_zero("reset");
    step();
    chk_idle_zero("idle_hold");

    run_scan(2'b11, 0, 1'b0);
    step(); step();
    chk("count_hold_idle", count, 4);
    run_scan(2'b10, 0, 1'b0);
    step();
    run_scan(2'b00, 5, 1'b0);
    step();
    run_scan(2'b01, 0, 1'b1);
    step();

    // Reset during HOLD while out_data=2 is being offered
    start = 1'b1; code = 2'b11; out_ready = 1'b0;
    step();
    start = 1'b0;
    guard = 0;
    while (!(out_valid && out_data == 3'd2) && guard < 40) begin
      out_ready = out_valid;
      step();
      out_ready = 1'b0;
      guard++;
    end
    chk("reach_hold_2", out_data, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_zero("mid_hold_reset");
    step();
    chk("after_reset_idle", busy, 0);
    run_scan(2'b01, 0, 1'b0);

    // Back-to-back: second start on the first IDLE cycle after done
    step();
    run_scan(2'b00, 0, 1'b0);
    run_scan(2'b11, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      step();
      run_scan(2'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)));
    end

    // Reset and start on the same edge: reset wins
    step();
    rst = 1'b1; start = 1'b1; code = 2'b11;
    step();
    rst = 1'b0; start = 1'b0;
    chk_idle_zero("rst_start_same_edge");
    step();
    chk("rst_start_still_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcm_preimage_scan.md
# bcm_preimage_scan

Sequential inverse of the fixed 3-to-2 `bcm` code table. Given a 2-bit code, it scans all eight 3-bit inputs in ascending order and emits every input whose `bcm` code equals the target, one per valid/ready handshake. It then pulses `done` with the match count. It sits downstream of `bcm`-style encoders in the lab datapath, so a test harness or controller can recover the candidate source values for an observed code.

## Interface
- Parameters: none. The code table is fixed: F(0)=11, F(1)=01, F(2)=11, F(3)=00, F(4)=11, F(5)=11, F(6)=00, F(7)=00.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  request a scan; sampled only in IDLE.
- `code`  in  2  target code; latched on the accepted `start` edge.
- `busy`  out  1  high whenever state ≠ IDLE.
- `out_valid`  out  1  `out_data` holds a matching input.
- `out_data`  out  3  matching input value.
- `out_ready`  in  1  consumer accepts `out_data`.
- `done`  out  1  one-cycle pulse at end of scan.
- `count`  out  3  matches delivered in the current or last scan (0..4).

## Operation
- Registers:
  - state (IDLE, SCAN, HOLD, DONE)
  - `idx[2:0]`
  - `code_q[1:0]`
  - `out_valid`, `out_data`, `count`
- Reset (any state, mid-scan included): state=IDLE, `idx`=0, `code_q`=0, `out_valid`=0, `out_data`=0, `count`=0. `busy`=0, `done`=0. A pending output is dropped.
- IDLE: on `start`=1, set `code_q`←`code`, `idx`←0, `count`←0, then go to SCAN. `start`=0 keeps IDLE and all outputs hold.
- SCAN: evaluate F(`idx`) against `code_q`.
  - Match: `out_valid`←1, `out_data`←`idx`, go to HOLD.
  - No match and `idx`=7: go to DONE.
  - No match otherwise: `idx`←`idx`+1, stay in SCAN.
- HOLD: `out_valid` and `out_data` are stable until `out_ready`=1 is sampled.
  - On the handshake: `out_valid`←0 and `count`←`count`+1.
  - Then if `idx`=7, go to DONE; else `idx`←`idx`+1 and go to SCAN.
  - With `out_ready`=0, stay in HOLD indefinitely.
- DONE: `done`=1 for this cycle only, then go to IDLE.
- Holding behaviour:
  - `count` holds its final value until the next accepted `start` or reset.
  - `out_data` keeps the last emitted value while `out_valid`=0.
- `start` while `busy`=1 (including the DONE cycle) is ignored; `code` is not re-latched.
- Match sets per code:
  - 00 → {3,6,7}
  - 01 → {1}
  - 10 → {} (empty; `done` with `count`=0, `out_valid` never asserted)
  - 11 → {0,2,4,5}
- `idx` never wraps. The scan terminates after `idx`=7 is evaluated.

## Timing
- Edge E0 samples `start` in IDLE; `busy`=1 from the cycle after E0.
- SCAN uses exactly one cycle per index. HOLD uses at least one cycle per match, exactly one when `out_ready` is held high.
- With `out_ready` tied high, a scan finding M matches spends 8 cycles in SCAN, M in HOLD, and 1 in DONE: `busy`=1 for 9+M cycles.
- `out_valid` rises the cycle after the SCAN cycle that found the match. The transfer completes on the first edge with `out_valid`=`out_ready`=1.
- `done` is high in the last busy cycle; `busy` and `done` fall together.
- The earliest next `start` is sampled on the edge ending the first IDLE cycle after DONE.
- `rst` and `start` asserted on the same edge: reset wins and the block stays in IDLE.
- All outputs are registered or decoded from state only. No combinational path from `out_ready` or `start` to any output.

## Test plan
- Reset, then `code`=11 with `start` for one cycle and `out_ready`=1 → `out_data` sequence 0,2,4,5; `done` 13 cycles after the start edge; `count`=4; `busy` high for 13 cycles.
- `code`=10 → no `out_valid`; `done` 9 cycles after start; `count`=0.
- `code`=00 with `out_ready` low for 5 cycles at each match → 3,6,7 held stable through the stalls, each accepted once; `count`=3.
- `code`=01; assert `start` with `code`=00 mid-scan and during the DONE cycle → both ignored; only output is 1; `count`=1.
- `code`=11; assert `rst` during HOLD with `out_data`=2 → the next cycle shows IDLE with all outputs 0; a fresh `code`=01 scan then runs normally.
- Back-to-back: `start` on the first IDLE cycle after `done` (code 00, then 11) → correct sets and counts for both; `count` holds 3 until the second start is accepted.
